centroid_stream: RTL and testbench
==================================

# centroid_stream

Parametrised streaming intensity-centroid engine for the ORB orientation stage. Accepts one N-pixel patch column per valid cycle and maintains sliding-window moments m00, m_x, m_y over the last N columns. Moments are produced at full precision and as MSB-truncated copies for the angle stage. Compared with the fixed 37-row centroid, it adds:
- generic patch size and pixel width
- valid-gated input with gaps
- row-start flush
- window-fill tracking, so moments are flagged only once the window is complete

## Interface
Parameters:
- W, 8 — unsigned pixel width
- N, 37 — patch diameter; odd, ≥3; R = (N-1)/2
- OUT_W, 10 — width of truncated moment outputs; OUT_W ≤ MW

Derived (package): WC = W + clog2(N+1); MW = W + clog2(N·R·(R+1)/2 + 1) + 1, giving 22 for W=8, N=37.

Ports:
- clk  in  1  — clock; all state on rising edge
- rst  in  1  — asynchronous, active-high reset
- in_valid  in  1  — column accepted this cycle
- in_flush  in  1  — qualified by in_valid; this column starts a new window
- in_corner  in  1  — corner tag travelling with the column
- in_col  in  N·W  — pixel k at bits [k·W +: W]; row y = k−R
- m00  out  MW  — unsigned Σ I over the window, zero-extended
- m_x  out  MW  — signed Σ x·I, x = −R (oldest column) … +R (newest column)
- m_y  out  MW  — signed Σ y·I
- m_x_t, m_y_t  out  OUT_W  — bits [MW-1 : MW-OUT_W] of m_x, m_y
- out_valid  out  1  — moments correspond to a full window ending at the tagged column
- out_corner  out  1  — out_valid & tag of that column

## Operation
- **Stage 0.** Register in_col, in_valid, in_flush and in_corner.
- **Stage 1 (`centroid_col_reduce`).** Compute column sum c = Σ I_k (WC bits, unsigned) and d = Σ (k−R)·I_k (signed, MW bits) and register them with the tags.
- **History.** A ring of N entries of (c, d) with an index pointer that wraps N−1 → 0. The entry overwritten by the incoming column is the outgoing column (c_out, d_out).
- **Stage 2 update** on a valid column, with S = m00 before the update:
  - m_y ← m_y + d − d_out
  - m00 ← S + c − c_out
  - m_x ← m_x − S + (R+1)·c_out + R·c
  - Results must equal the direct definitions for every window.
- **Fill counter.** Counts 0…N and saturates at N. out_valid = 1 on the update cycle in which the count reaches or is at N; otherwise 0.
- **Flush.**
  - A valid column with in_flush first clears m00, m_x, m_y, every history entry, the pointer and the fill counter.
  - It then applies its own update, so the count becomes 1.
  - Columns already in flight ahead of the flushed column complete against the old window, because the flush acts at stage 2 with its column.
- **Invalid cycles.** No state changes. Outputs hold their values; out_valid and out_corner drop to 0.
- **Arithmetic.** All accumulations are in MW bits, two's complement. By construction no overflow occurs within the declared widths.
- **Reset.** Asynchronous at any time, including mid-window. Clears every pipeline register, history entry, pointer, counter and output to 0. out_valid stays 0 until N new valid columns have been accepted.

## Timing
- Latency is 3 cycles: a column sampled at edge t produces its out_valid/moments at edge t+3.
- Throughput is one column per cycle with no back-pressure; in_valid gaps of any length are allowed.
- Moment outputs are registers, so there is no combinational path from inputs.
- A flush on back-to-back valid columns is legal every cycle; each flushed column restarts the count at 1.

## Structure
- **Package `centroid_pkg`:** a clog2 function, functions for WC and MW, and a localparam helper for R.
- **Sub-module `centroid_col_reduce`:** parameters W, N, and the output widths WC and MW. It is a combinational adder tree for c and d with signed row weights, registered by the parent.
- **Parent:** contains the stage registers, history ring, fill counter and moment update.

## Test plan
All scenarios use N=5, W=8 unless stated.
1. **Uniform patch.** Columns all 10 for 5 valid cycles → out_valid on the 5th result only; m00=250, m_x=0, m_y=0.
2. **Single bright pixel.** Pixel 100 at k=4 in column 5 (prior columns 0) → m_x=200, m_y=200. One more zero column → m_x=100, m_y=200, m00=100.
3. **Input gaps.** Same stimulus as scenario 1 with in_valid toggled 1-0-0-1… → identical values; out_valid only on valid-derived cycles; outputs hold across gaps.
4. **Flush mid-stream.**
   - 7 columns of 10, then a flush column of 20.
   - Next 3 results: out_valid=0, m00=100, 200, 300.
   - After 4 more columns of 20: m00=500, out_valid=1.
5. **Reset during operation.** Assert rst mid-window → all outputs 0 immediately. After release, out_valid is first seen only on the 5th new valid column.
6. **Full-scale, N=37.**
   - Pixels 255 where x>0 and y>0, else 0.
   - Full window → m_x = m_y = 784890, m00 = 82620.
   - m_x_t = m_y_t = 784890 >> 12 = 191.
   - out_corner mirrors the in_corner tag of the final column.

Source files
------------

// File: rtl/centroid_pkg.sv
// centroid_pkg: width helpers shared by the centroid engine and its column reducer
package centroid_pkg;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int r_of(input int n);
    return (n - 1) / 2;
  endfunction
  function automatic int wc_of(input int w, input int n);
    return w + clog2(n + 1);
  endfunction
  // Largest |m_x| is N*255*R(R+1)/2; one extra bit for the sign.
  function automatic int mw_of(input int w, input int n);
    int r;
    r = r_of(n);
    return w + clog2(n * r * (r + 1) / 2 + 1) + 1;
  endfunction
endpackage

// File: rtl/centroid_col_reduce.sv
// centroid_col_reduce: combinational column sum c and row-weighted sum d of one patch column
//   col : N pixels, pixel k at [k*W +: W], row weight k-R
//   c   : unsigned sum of pixels (WC bits)
//   d   : signed sum of (k-R)*pixel (MW bits, two's complement)
module centroid_col_reduce
  import centroid_pkg::*;
#(
  parameter int W  = 8,
  parameter int N  = 37,
  parameter int WC = wc_of(W, N),
  parameter int MW = mw_of(W, N)
) (
  input  logic [N*W-1:0] col,
  output logic [WC-1:0]  c,
  output logic [MW-1:0]  d
);
  localparam int R = r_of(N);
  always_comb begin
    c = '0;
    d = '0;
    for (int k = 0; k < N; k++) begin
      c = c + WC'(col[k*W +: W]);
      d = d + MW'((k - R) * int'(col[k*W +: W]));
    end
  end
endmodule

// File: rtl/centroid_stream.sv
// centroid_stream: sliding-window intensity centroid moments over the last N patch columns
//   in_valid/in_flush/in_corner/in_col : one column per valid cycle; flush restarts the window
//   m00, m_x, m_y                      : full-precision moments (registered, hold across gaps)
//   m_x_t, m_y_t                       : top OUT_W bits of m_x, m_y
//   out_valid, out_corner              : window complete at this column / its corner tag
module centroid_stream
  import centroid_pkg::*;
#(
  parameter int W     = 8,
  parameter int N     = 37,
  parameter int OUT_W = 10,
  localparam int R    = r_of(N),
  localparam int WC   = wc_of(W, N),
  localparam int MW   = mw_of(W, N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_flush,
  input  logic             in_corner,
  input  logic [N*W-1:0]   in_col,
  output logic [MW-1:0]    m00,
  output logic [MW-1:0]    m_x,
  output logic [MW-1:0]    m_y,
  output logic [OUT_W-1:0] m_x_t,
  output logic [OUT_W-1:0] m_y_t,
  output logic             out_valid,
  output logic             out_corner
);
  localparam int PW = clog2(N);
  localparam int CW = clog2(N + 1);
  localparam logic [MW-1:0] RR  = MW'(R);
  localparam logic [MW-1:0] RP1 = MW'(R + 1);
  logic [N*W-1:0] s0_col;
  logic           s0_v, s0_f, s0_cr;
  logic [WC-1:0]  c, s1_c;
  logic [MW-1:0]  d, s1_d;
  logic           s1_v, s1_f, s1_cr;
  logic           s2_v, s2_full, s2_cr;
  logic [WC-1:0]  hc [N];
  logic [MW-1:0]  hd [N];
  logic [PW-1:0]  ptr, ptr_b, ptr_n;
  logic [CW-1:0]  cnt, cnt_b, cnt_n;
  logic [MW-1:0]  a00, ax, ay, b00, bx, by, c_out, d_out, a00_n, ax_n, ay_n;
  centroid_col_reduce #(.W(W), .N(N), .WC(WC), .MW(MW)) u_reduce (
    .col(s0_col),
    .c  (c),
    .d  (d)
  );
  // A flushed column sees an empty window: zeroed moments, history, pointer and count.
  always_comb begin
    b00   = s1_f ? '0 : a00;
    bx    = s1_f ? '0 : ax;
    by    = s1_f ? '0 : ay;
    ptr_b = s1_f ? '0 : ptr;
    cnt_b = s1_f ? '0 : cnt;
    c_out = s1_f ? '0 : MW'(hc[ptr]);
    d_out = s1_f ? '0 : hd[ptr];
    a00_n = b00 + MW'(s1_c) - c_out;
    // Every retained column shifts one step toward -R; the evicted one leaves from -(R+1).
    ax_n  = bx - b00 + RP1 * c_out + RR * MW'(s1_c);
    ay_n  = by + s1_d - d_out;
    ptr_n = (ptr_b == PW'(N - 1)) ? '0 : ptr_b + PW'(1);
    cnt_n = (cnt_b == CW'(N)) ? cnt_b : cnt_b + CW'(1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_col     <= '0;
      s0_v       <= 1'b0;
      s0_f       <= 1'b0;
      s0_cr      <= 1'b0;
      s1_c       <= '0;
      s1_d       <= '0;
      s1_v       <= 1'b0;
      s1_f       <= 1'b0;
      s1_cr      <= 1'b0;
      s2_v       <= 1'b0;
      s2_full    <= 1'b0;
      s2_cr      <= 1'b0;
      ptr        <= '0;
      cnt        <= '0;
      a00        <= '0;
      ax         <= '0;
      ay         <= '0;
      m00        <= '0;
      m_x        <= '0;
      m_y        <= '0;
      out_valid  <= 1'b0;
      out_corner <= 1'b0;
      for (int i = 0; i < N; i++) begin
        hc[i] <= '0;
        hd[i] <= '0;
      end
    end else begin
      s0_col  <= in_col;
      s0_v    <= in_valid;
      s0_f    <= in_valid & in_flush;
      s0_cr   <= in_corner;
      s1_c    <= c;
      s1_d    <= d;
      s1_v    <= s0_v;
      s1_f    <= s0_v & s0_f;
      s1_cr   <= s0_cr;
      s2_v    <= s1_v;
      s2_full <= cnt_n == CW'(N);
      s2_cr   <= s1_cr;
      if (s1_v) begin
        a00 <= a00_n;
        ax  <= ax_n;
        ay  <= ay_n;
        ptr <= ptr_n;
        cnt <= cnt_n;
        for (int i = 0; i < N; i++) begin
          if (s1_f) begin
            hc[i] <= '0;
            hd[i] <= '0;
          end
        end
        hc[ptr_b] <= s1_c;
        hd[ptr_b] <= s1_d;
      end
      out_valid  <= s2_v & s2_full;
      out_corner <= s2_v & s2_full & s2_cr;
      if (s2_v) begin
        m00 <= a00;
        m_x <= ax;
        m_y <= ay;
      end
    end
  end
  assign m_x_t = m_x[MW-1 -: OUT_W];
  assign m_y_t = m_y[MW-1 -: OUT_W];
endmodule

// File: tb/tb_centroid_stream.sv
// tb_centroid_stream: directed table-driven checks of centroid_stream at N=5 and N=37
module tb_centroid_stream;
  import centroid_pkg::*;
  localparam int MW5  = mw_of(8, 5);
  localparam int MW37 = mw_of(8, 37);
  localparam int OW   = 10;
  typedef struct {
    logic        v, f, cr;
    logic [39:0] col;
    logic        ov, oc;
    int          m00, mx, my;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic            v5 = 1'b0, f5 = 1'b0, cr5 = 1'b0;
  logic [39:0]     col5 = '0;
  logic [MW5-1:0]  m00_5, mx5, my5;
  logic [OW-1:0]   mxt5, myt5;
  logic            ov5, oc5;
  logic            v37 = 1'b0, f37 = 1'b0, cr37 = 1'b0;
  logic [295:0]    col37 = '0;
  logic [MW37-1:0] m00_37, mx37, my37;
  logic [OW-1:0]   mxt37, myt37;
  logic            ov37, oc37;
  int checks = 0;
  int failures = 0;
  vec_t tab[$];
  centroid_stream #(.W(8), .N(5), .OUT_W(OW)) dut5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_flush(f5), .in_corner(cr5), .in_col(col5),
    .m00(m00_5), .m_x(mx5), .m_y(my5), .m_x_t(mxt5), .m_y_t(myt5),
    .out_valid(ov5), .out_corner(oc5)
  );
  centroid_stream #(.W(8), .N(37), .OUT_W(OW)) dut37 (
    .clk(clk), .rst(rst), .in_valid(v37), .in_flush(f37), .in_corner(cr37), .in_col(col37),
    .m00(m00_37), .m_x(mx37), .m_y(my37), .m_x_t(mxt37), .m_y_t(myt37),
    .out_valid(ov37), .out_corner(oc37)
  );
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic v, f, cr, input logic [39:0] col,
                              input logic ov, oc, input int m00, mx, my);
    vec_t r;
    r.v = v; r.f = f; r.cr = cr; r.col = col;
    r.ov = ov; r.oc = oc; r.m00 = m00; r.mx = mx; r.my = my;
    return r;
  endfunction
  function automatic logic [39:0] uni(input logic [7:0] p);
    return {5{p}};
  endfunction
  function automatic logic [39:0] one(input int k, input logic [7:0] p);
    logic [39:0] r;
    r = '0;
    r[k*8 +: 8] = p;
    return r;
  endfunction
  function automatic logic [OW-1:0] tr5(input int x);
    int t;
    t = x >>> (MW5 - OW);
    return t[OW-1:0];
  endfunction
  task automatic check5(input string tag, input vec_t e);
    chk({tag, " out_valid"},  int'(ov5), int'(e.ov));
    chk({tag, " out_corner"}, int'(oc5), int'(e.oc));
    chk({tag, " m00"}, int'(m00_5), e.m00);
    chk({tag, " m_x"}, int'($signed(mx5)), e.mx);
    chk({tag, " m_y"}, int'($signed(my5)), e.my);
    chk({tag, " m_x_t"}, int'(mxt5), int'(tr5(e.mx)));
    chk({tag, " m_y_t"}, int'(myt5), int'(tr5(e.my)));
  endtask
  initial begin
    // uniform patch of 10: c=50, d=0
    tab.push_back(mk(1, 0, 0, uni(10), 0, 0, 50, 100, 0));
    tab.push_back(mk(1, 0, 0, uni(10), 0, 0, 100, 150, 0));
    tab.push_back(mk(1, 0, 0, uni(10), 0, 0, 150, 150, 0));
    tab.push_back(mk(1, 0, 0, uni(10), 0, 0, 200, 100, 0));
    tab.push_back(mk(1, 0, 0, uni(10), 1, 0, 250, 0, 0));
    // single bright pixel, preceded by a flushed empty window
    tab.push_back(mk(1, 1, 1, '0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 0, '0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 0, '0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 0, '0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 0, 1, one(4, 100), 1, 1, 100, 200, 200));
    tab.push_back(mk(1, 0, 0, '0, 1, 0, 100, 100, 200));
    tab.push_back(mk(1, 0, 0, one(0, 40), 1, 0, 140, 80, 120));
    // gaps: invalid cycles carry junk with flush/corner high and must be ignored
    tab.push_back(mk(1, 1, 0, uni(10), 0, 0, 50, 100, 0));
    tab.push_back(mk(0, 1, 1, uni(255), 0, 0, 50, 100, 0));
    tab.push_back(mk(0, 1, 1, uni(255), 0, 0, 50, 100, 0));
    tab.push_back(mk(1, 0, 0, uni(10), 0, 0, 100, 150, 0));
    tab.push_back(mk(0, 1, 1, uni(255), 0, 0, 100, 150, 0));
    tab.push_back(mk(0, 1, 1, uni(255), 0, 0, 100, 150, 0));
    tab.push_back(mk(1, 0, 0, uni(10), 0, 0, 150, 150, 0));
    tab.push_back(mk(0, 1, 1, uni(255), 0, 0, 150, 150, 0));
    tab.push_back(mk(1, 0, 0, uni(10), 0, 0, 200, 100, 0));
    tab.push_back(mk(0, 1, 1, uni(255), 0, 0, 200, 100, 0));
    tab.push_back(mk(1, 0, 1, uni(10), 1, 1, 250, 0, 0));
    tab.push_back(mk(0, 1, 1, uni(255), 0, 0, 250, 0, 0));
    tab.push_back(mk(1, 0, 0, uni(10), 1, 0, 250, 0, 0));
    // flush mid-stream: 7 columns of 10 then flush column of 20 (c=100)
    tab.push_back(mk(1, 1, 0, uni(10), 0, 0, 50, 100, 0));
    tab.push_back(mk(1, 0, 0, uni(10), 0, 0, 100, 150, 0));
    tab.push_back(mk(1, 0, 0, uni(10), 0, 0, 150, 150, 0));
    tab.push_back(mk(1, 0, 0, uni(10), 0, 0, 200, 100, 0));
    tab.push_back(mk(1, 0, 0, uni(10), 1, 0, 250, 0, 0));
    tab.push_back(mk(1, 0, 0, uni(10), 1, 0, 250, 0, 0));
    tab.push_back(mk(1, 0, 0, uni(10), 1, 0, 250, 0, 0));
    tab.push_back(mk(1, 1, 0, uni(20), 0, 0, 100, 200, 0));
    tab.push_back(mk(1, 0, 0, uni(20), 0, 0, 200, 300, 0));
    tab.push_back(mk(1, 0, 0, uni(20), 0, 0, 300, 300, 0));
    tab.push_back(mk(1, 0, 0, uni(20), 0, 0, 400, 200, 0));
    tab.push_back(mk(1, 0, 0, uni(20), 1, 0, 500, 0, 0));
    tab.push_back(mk(1, 0, 0, uni(20), 1, 0, 500, 0, 0));
    // back-to-back flushes each restart the count
    tab.push_back(mk(1, 1, 1, uni(10), 0, 0, 50, 100, 0));
    tab.push_back(mk(1, 1, 1, uni(10), 0, 0, 50, 100, 0));
    #12;
    chk("reset out_valid5", int'(ov5), 0);
    chk("reset m00_5", int'(m00_5), 0);
    chk("reset m_x5", int'(mx5), 0);
    chk("reset m_y5", int'(my5), 0);
    chk("reset out_valid37", int'(ov37), 0);
    chk("reset m00_37", int'(m00_37), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < tab.size() + 3; i++) begin
      if (i < tab.size()) begin
        v5 = tab[i].v; f5 = tab[i].f; cr5 = tab[i].cr; col5 = tab[i].col;
      end else begin
        v5 = 1'b0; f5 = 1'b0; cr5 = 1'b0; col5 = '0;
      end
      @(posedge clk);
      #1;
      if (i >= 3) check5($sformatf("row%0d", i - 3), tab[i - 3]);
    end
    // asynchronous reset with a column in flight
    v5 = 1'b1; f5 = 1'b0; cr5 = 1'b0; col5 = uni(10);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst m00", int'(m00_5), 0);
    chk("async rst m_x", int'(mx5), 0);
    chk("async rst m_y", int'(my5), 0);
    chk("async rst out_valid", int'(ov5), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v5 = (i < 5);
      @(posedge clk);
      #1;
      if (i < 3) begin
        chk($sformatf("post rst idle%0d m00", i), int'(m00_5), 0);
        chk($sformatf("post rst idle%0d out_valid", i), int'(ov5), 0);
      end else begin
        chk($sformatf("post rst col%0d m00", i - 3), int'(m00_5), 50 * (i - 2));
        chk($sformatf("post rst col%0d out_valid", i - 3), int'(ov5), int'(i == 7));
      end
    end
    v5 = 1'b0;
    // full-scale N=37: pixels 255 where x>0 and y>0
    for (int i = 0; i < 37; i++) begin
      for (int k = 0; k < 37; k++) col37[k*8 +: 8] = (i > 18 && k > 18) ? 8'd255 : 8'd0;
      v37 = 1'b1;
      cr37 = (i == 36);
      @(posedge clk);
      #1;
    end
    v37 = 1'b0;
    cr37 = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("n37 col35 out_valid", int'(ov37), 0);
    @(posedge clk);
    #1;
    chk("n37 out_valid", int'(ov37), 1);
    chk("n37 out_corner", int'(oc37), 1);
    chk("n37 m00", int'(m00_37), 82620);
    chk("n37 m_x", int'($signed(mx37)), 784890);
    chk("n37 m_y", int'($signed(my37)), 784890);
    chk("n37 m_x_t", int'(mxt37), 191);
    chk("n37 m_y_t", int'(myt37), 191);
    @(posedge clk);
    #1;
    chk("n37 gap out_valid", int'(ov37), 0);
    chk("n37 gap out_corner", int'(oc37), 0);
    chk("n37 gap m00 hold", int'(m00_37), 82620);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
